fir_cfg_seq: RTL and testbench

FIR_CFG_SEQ -- requirements
Module: fir_cfg_seq

---
 rtl/fir_cfg_seq_pkg.sv | 21 ++
 rtl/fir_cfg_seq_if.sv | 31 +++
 rtl/fir_cfg_seq_stage_ram.sv | 28 ++
 rtl/fir_cfg_seq.sv | 169 ++++++++++++++++
 tb/tb_fir_cfg_seq.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_cfg_seq_pkg.sv
// Shared DSP definitions for the FIR coefficient configuration sequencer:
// default filter dimensions and the sequencer state encoding.
package fir_cfg_seq_pkg;

  localparam int dsp_coef_width = 24;
  localparam int dsp_coef_count = 16;
  localparam int dsp_max_shift  = 32;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    FLUSH_PRE  = 4'd1,
    LOAD       = 4'd2,
    WAIT_ACK   = 4'd3,
    SHIFT      = 4'd4,
    WAIT_SHIFT = 4'd5,
    FLUSH_POST = 4'd6,
    DONE       = 4'd7,
    ERR        = 4'd8
  } cfg_state_t;

endpackage

// File: rtl/fir_cfg_seq_if.sv
// Filter-side programming bus between the configuration sequencer (master)
// and the FIR filter (slave).
interface fir_cfg_seq_if
  import fir_cfg_seq_pkg::*;
#(
  parameter int coef_width  = dsp_coef_width,
  parameter int coef_id_w   = $clog2(dsp_coef_count),
  parameter int max_shift_w = $clog2(dsp_max_shift)
) ();

  logic [coef_id_w-1:0]   f_addr;
  logic [coef_width-1:0]  f_coef;
  logic                   f_coef_ready;
  logic                   f_coef_done;
  logic [max_shift_w-1:0] f_shift;
  logic                   f_shift_ready;
  logic                   f_shift_done;
  logic                   f_flush;
  logic                   conv_gate;

  modport master (
    output f_addr, f_coef, f_coef_ready, f_shift, f_shift_ready, f_flush, conv_gate,
    input  f_coef_done, f_shift_done
  );

  modport slave (
    input  f_addr, f_coef, f_coef_ready, f_shift, f_shift_ready, f_flush, conv_gate,
    output f_coef_done, f_shift_done
  );

endinterface

// File: rtl/fir_cfg_seq_stage_ram.sv
// Coefficient staging buffer: one synchronous write port, one asynchronous
// read port. Deliberately not reset so staged values survive a sequencer reset.
module cfg_stage_ram
  import fir_cfg_seq_pkg::*;
#(
  parameter int width = dsp_coef_width,
  parameter int depth = dsp_coef_count,
  localparam int aw   = $clog2(depth)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [aw-1:0]    waddr,
  input  logic [width-1:0] wdata,
  input  logic [aw-1:0]    raddr,
  output logic [width-1:0] rdata
);

  logic [width-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fir_cfg_seq.sv
// FIR configuration sequencer: flushes the filter, streams the staged
// coefficients with per-tap handshakes, programs the result shift, flushes again.
//
// state      | meaning
// IDLE       | host may stage coefficients and commit; filter conversions allowed
// FLUSH_PRE  | one-cycle flush before programming
// LOAD       | present tap idx, one-cycle f_coef_ready
// WAIT_ACK   | hold tap, wait for f_coef_done (timeout-guarded)
// SHIFT      | present latched shift, one-cycle f_shift_ready
// WAIT_SHIFT | wait for f_shift_done (timeout-guarded)
// FLUSH_POST | one-cycle flush after programming
// DONE       | one-cycle cfg_done
// ERR        | one-cycle cfg_err plus flush after an acknowledge timeout
module fir_cfg_seq
  import fir_cfg_seq_pkg::*;
#(
  parameter int coef_width   = dsp_coef_width,
  parameter int coef_count   = dsp_coef_count,
  parameter int max_shift    = dsp_max_shift,
  parameter int ack_timeout  = 8,
  localparam int coef_id_w   = $clog2(coef_count),
  localparam int max_shift_w = $clog2(max_shift)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [coef_id_w-1:0]   wr_addr,
  input  logic [coef_width-1:0]  wr_data,
  input  logic [max_shift_w-1:0] shift_in,
  input  logic                   commit,
  output logic                   busy,
  output logic                   cfg_done,
  output logic                   cfg_err,
  fir_cfg_seq_if.master          fbus
);

  localparam int tmo_w = $clog2(ack_timeout + 1);
  localparam logic [tmo_w-1:0]     tmo_load = tmo_w'(ack_timeout - 1);
  localparam logic [coef_id_w-1:0] idx_last = coef_id_w'(coef_count - 1);

  cfg_state_t             state, state_nx;
  logic [coef_id_w-1:0]   idx, idx_nx;
  logic [tmo_w-1:0]       tmo_cnt, tmo_nx;
  logic [max_shift_w-1:0] shift_q, shift_nx;
  logic [coef_width-1:0]  stage_rdata;
  logic                   stage_we;
  logic                   flush, coef_ready, shift_ready, done_pls, err_pls;
  logic                   coef_phase, shift_phase;

  // Host writes are only honoured while the filter is not being programmed.
  assign stage_we = wr_en && (state == IDLE);

  cfg_stage_ram #(
    .width (coef_width),
    .depth (coef_count)
  ) u_stage (
    .clk   (clk),
    .we    (stage_we),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (idx),
    .rdata (stage_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      tmo_cnt <= '0;
      shift_q <= '0;
    end else begin
      state   <= state_nx;
      idx     <= idx_nx;
      tmo_cnt <= tmo_nx;
      shift_q <= shift_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    idx_nx      = idx;
    tmo_nx      = tmo_cnt;
    shift_nx    = shift_q;
    flush       = 1'b0;
    coef_ready  = 1'b0;
    shift_ready = 1'b0;
    done_pls    = 1'b0;
    err_pls     = 1'b0;
    case (state)
      IDLE: begin
        if (commit) begin
          state_nx = FLUSH_PRE;
          shift_nx = shift_in;
          idx_nx   = '0;
        end
      end
      FLUSH_PRE: begin
        flush    = 1'b1;
        state_nx = LOAD;
      end
      LOAD: begin
        coef_ready = 1'b1;
        tmo_nx     = tmo_load;
        state_nx   = WAIT_ACK;
      end
      // Down-counter loaded on entry; reaching zero without an ack is the timeout.
      WAIT_ACK: begin
        if (fbus.f_coef_done) begin
          if (idx == idx_last) begin
            state_nx = SHIFT;
          end else begin
            idx_nx   = idx + coef_id_w'(1);
            state_nx = LOAD;
          end
        end else if (tmo_cnt == '0) begin
          state_nx = ERR;
        end else begin
          tmo_nx = tmo_cnt - tmo_w'(1);
        end
      end
      SHIFT: begin
        shift_ready = 1'b1;
        tmo_nx      = tmo_load;
        state_nx    = WAIT_SHIFT;
      end
      WAIT_SHIFT: begin
        if (fbus.f_shift_done) begin
          state_nx = FLUSH_POST;
        end else if (tmo_cnt == '0) begin
          state_nx = ERR;
        end else begin
          tmo_nx = tmo_cnt - tmo_w'(1);
        end
      end
      FLUSH_POST: begin
        flush    = 1'b1;
        state_nx = DONE;
      end
      DONE: begin
        done_pls = 1'b1;
        state_nx = IDLE;
      end
      ERR: begin
        err_pls  = 1'b1;
        flush    = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Data outputs are gated so they read zero outside their handshake phases.
  assign coef_phase  = (state == LOAD) || (state == WAIT_ACK);
  assign shift_phase = (state == SHIFT) || (state == WAIT_SHIFT);

  assign busy               = (state != IDLE);
  assign cfg_done           = done_pls;
  assign cfg_err            = err_pls;
  assign fbus.conv_gate     = (state != IDLE);
  assign fbus.f_flush       = flush;
  assign fbus.f_coef_ready  = coef_ready;
  assign fbus.f_shift_ready = shift_ready;
  assign fbus.f_addr        = coef_phase ? idx : '0;
  assign fbus.f_coef        = coef_phase ? stage_rdata : '0;
  assign fbus.f_shift       = shift_phase ? shift_q : '0;

endmodule

// File: tb/tb_fir_cfg_seq.sv
// Bench for fir_cfg_seq: timeline model of the programming sequence derived
// from the handshake rules, checked every cycle, plus literal spot checks.
module tb_fir_cfg_seq;
  import fir_cfg_seq_pkg::*;

  localparam int N   = 16;
  localparam int CW  = 24;
  localparam int AW  = 4;
  localparam int SW  = 5;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic          commit = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [CW-1:0] wr_data = '0;
  logic [SW-1:0] shift_in = '0;
  logic          busy, cfg_done, cfg_err;

  fir_cfg_seq_if #(.coef_width(CW), .coef_id_w(AW), .max_shift_w(SW)) fb ();

  fir_cfg_seq #(
    .coef_width(CW), .coef_count(N), .max_shift(32), .ack_timeout(TMO)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .shift_in(shift_in), .commit(commit), .busy(busy), .cfg_done(cfg_done),
    .cfg_err(cfg_err), .fbus(fb)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Filter model: acknowledges two edges after a ready pulse; can refuse one tap.
  int   stall_idx = -1;
  logic c_r1 = 1'b0, c_done = 1'b0, s_r1 = 1'b0, s_done = 1'b0;
  always @(posedge clk) begin
    c_r1   <= fb.f_coef_ready && !(stall_idx >= 0 && int'(fb.f_addr) == stall_idx);
    c_done <= c_r1;
    s_r1   <= fb.f_shift_ready;
    s_done <= s_r1;
  end
  assign fb.f_coef_done  = c_done;
  assign fb.f_shift_done = s_done;

  // Sequence model: each accepted commit yields a fixed event timeline.
  logic [CW-1:0] stage_m [N];
  bit            active = 1'b0;
  int            c0 = 0, seq_stall = -1, abort_at = 0;
  logic [SW-1:0] seq_shift = '0;

  function automatic int end_d();
    return (seq_stall >= 0) ? 3 * seq_stall + 11 : 3 * N + 6;
  endfunction

  function automatic bit in_seq(int t);
    int d = t - c0;
    return active && (t <= abort_at) && (d >= 1) && (d <= end_d());
  endfunction

  int tests = 0, fails = 0;
  bit chk_en = 1'b0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  int            rdy_cnt = 0, done_cnt = 0, err_cnt = 0, flush_cnt = 0;
  int            done_cyc = 0, err_cyc = 0;
  longint        coef_sum = 0;
  logic [N-1:0]  addr_mask = '0;
  logic [CW-1:0] seen_coef [N];
  logic [AW-1:0] first_addr = '0;
  logic [CW-1:0] first_coef = '0;
  logic [SW-1:0] shift_seen = '0;

  always @(negedge clk) begin : cmp_blk
    int d, k, last_k, win_end;
    bit on, e_err;
    if (chk_en) begin
      d       = cyc - c0;
      on      = in_seq(cyc);
      last_k  = (seq_stall >= 0) ? seq_stall : N - 1;
      win_end = (seq_stall >= 0) ? 3 * seq_stall + 10 : 3 * N + 1;
      e_err   = on && seq_stall >= 0 && d == 3 * seq_stall + 11;
      chk("busy", busy, on);
      chk("conv_gate", fb.conv_gate, on);
      chk("cfg_done", cfg_done, on && seq_stall < 0 && d == 3 * N + 6);
      chk("cfg_err", cfg_err, e_err);
      chk("f_flush", fb.f_flush, on && (d == 1 || (seq_stall < 0 && d == 3 * N + 5) || e_err));
      chk("f_coef_ready", fb.f_coef_ready,
          on && d >= 2 && (d - 2) % 3 == 0 && (d - 2) / 3 <= last_k);
      chk("f_shift_ready", fb.f_shift_ready, on && seq_stall < 0 && d == 3 * N + 2);
      if (on && d >= 2 && d <= win_end) begin
        k = (d - 2) / 3;
        if (k > last_k) k = last_k;
        chk("f_addr", fb.f_addr, k);
        chk("f_coef", fb.f_coef, stage_m[k]);
      end
      if (on && seq_stall < 0 && d >= 3 * N + 2 && d <= 3 * N + 4)
        chk("f_shift", fb.f_shift, seq_shift);

      if (fb.f_coef_ready) begin
        rdy_cnt++;
        coef_sum += longint'(fb.f_coef);
        addr_mask[fb.f_addr] = 1'b1;
        seen_coef[fb.f_addr] = fb.f_coef;
        if (rdy_cnt == 1) begin
          first_addr = fb.f_addr;
          first_coef = fb.f_coef;
        end
      end
      if (fb.f_shift_ready) shift_seen = fb.f_shift;
      if (cfg_done) begin done_cnt++; done_cyc = cyc; end
      if (cfg_err)  begin err_cnt++;  err_cyc  = cyc; end
      if (fb.f_flush) flush_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_mon();
    rdy_cnt = 0; done_cnt = 0; err_cnt = 0; flush_cnt = 0;
    coef_sum = 0; addr_mask = '0;
  endtask

  task automatic model_write(int a, logic [CW-1:0] v);
    if (!in_seq(cyc)) stage_m[a] = v;
  endtask

  task automatic model_commit();
    if (!in_seq(cyc)) begin
      active    = 1'b1;
      c0        = cyc;
      seq_stall = stall_idx;
      seq_shift = shift_in;
      abort_at  = 32'h7fff_ffff;
    end
  endtask

  task automatic host_write(int a, logic [CW-1:0] v);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = v;
    model_write(a, v);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    model_commit();
    tick();
    commit = 1'b0;
  endtask

  task automatic wait_end(string nm, int bound);
    int base = done_cnt + err_cnt;
    int i = 0;
    while (done_cnt + err_cnt == base && i < bound) begin
      tick();
      i++;
    end
    tests++;
    if (done_cnt + err_cnt == base) begin
      fails++;
      $display("FAIL %s: no cfg_done/cfg_err within %0d cycles", nm, bound);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk_en = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_conv_gate", fb.conv_gate, 0);
    chk("rst_f_flush", fb.f_flush, 0);
    chk("rst_f_addr", fb.f_addr, 0);
    chk("rst_f_coef", fb.f_coef, 0);

    // Full sequence with prompt acknowledges.
    for (int k = 0; k < N; k++) host_write(k, CW'(k + 1));
    shift_in = 5'd4;
    clr_mon();
    do_commit();
    wait_end("basic_seq", 200);
    repeat (3) tick();
    chk("basic_done_latency", done_cyc - c0, 54);
    chk("basic_ready_count", rdy_cnt, 16);
    chk("basic_addr_mask", addr_mask, 16'hffff);
    chk("basic_coef_sum", coef_sum, 136);
    chk("basic_coef_15", seen_coef[15], 16);
    chk("basic_shift", shift_seen, 4);
    chk("basic_err_count", err_cnt, 0);

    // Filter never acknowledges tap 5.
    stall_idx = 5;
    shift_in  = 5'd7;
    clr_mon();
    do_commit();
    wait_end("timeout_seq", 200);
    repeat (3) tick();
    stall_idx = -1;
    chk("tmo_err_latency", err_cyc - c0, 26);
    chk("tmo_done_count", done_cnt, 0);
    chk("tmo_err_count", err_cnt, 1);
    chk("tmo_flush_count", flush_cnt, 2);
    chk("tmo_ready_count", rdy_cnt, 6);
    chk("tmo_busy_after", busy, 0);

    // Write and commit in the same idle cycle.
    shift_in = 5'd4;
    clr_mon();
    wr_en = 1'b1; wr_addr = '0; wr_data = 24'hABCDEF;
    model_write(0, 24'hABCDEF);
    commit = 1'b1;
    model_commit();
    tick();
    wr_en = 1'b0; commit = 1'b0;
    wait_end("same_cycle_seq", 200);
    repeat (3) tick();
    chk("same_cycle_first_addr", first_addr, 0);
    chk("same_cycle_first_coef", first_coef, 24'hABCDEF);
    chk("same_cycle_done_count", done_cnt, 1);

    // Write and a second commit while busy are both ignored.
    clr_mon();
    do_commit();
    repeat (8) tick();
    wr_en = 1'b1; wr_addr = AW'(3); wr_data = 24'h123456;
    model_write(3, 24'h123456);
    commit = 1'b1;
    model_commit();
    tick();
    wr_en = 1'b0; commit = 1'b0;
    wait_end("busy_ignore_seq", 200);
    repeat (20) tick();
    chk("busy_ignore_done_count", done_cnt, 1);
    chk("busy_ignore_err_count", err_cnt, 0);
    chk("busy_ignore_idle", busy, 0);

    // Reset during LOAD of tap 7.
    clr_mon();
    do_commit();
    repeat (22) tick();
    rst = 1'b1;
    abort_at = cyc;
    tick();
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_conv_gate", fb.conv_gate, 0);
    chk("abort_f_coef_ready", fb.f_coef_ready, 0);
    chk("abort_f_flush", fb.f_flush, 0);
    chk("abort_f_addr", fb.f_addr, 0);
    chk("abort_f_coef", fb.f_coef, 0);
    chk("abort_f_shift", fb.f_shift, 0);
    repeat (20) tick();
    chk("abort_done_count", done_cnt, 0);
    chk("abort_err_count", err_cnt, 0);
    chk("abort_ready_count", rdy_cnt, 8);

    // Fresh commit after the abort uses the retained staging contents.
    clr_mon();
    do_commit();
    wait_end("post_abort_seq", 200);
    repeat (3) tick();
    chk("post_abort_done_latency", done_cyc - c0, 54);
    chk("post_abort_coef_0", seen_coef[0], 24'hABCDEF);
    chk("post_abort_coef_3", seen_coef[3], 4);
    chk("post_abort_coef_15", seen_coef[15], 16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
